// File: rtl/multiword_add_seq.sv
// Sequential wide adder/subtractor: one W-bit limb per cycle
// through a single Kogge-Stone prefix adder with carry-in.
module multiword_add_seq #(
  parameter int W     = 32,
  parameter int LIMBS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*LIMBS-1:0] a,
  input  logic [W*LIMBS-1:0] b,
  input  logic               op_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*LIMBS-1:0] sum,
  output logic               cout,
  output logic               busy
);

  localparam int N  = W * LIMBS;
  localparam int IW = $clog2(LIMBS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  sum_r;
  logic          cout_r;
  logic          carry;
  logic [IW-1:0] idx;
  logic          accept;
  logic          last;
  logic [W-1:0]  la;
  logic [W-1:0]  lb;
  logic [W:0]    ks;

  // Kogge-Stone: carry-in folded into bit 0 generate,
  // log2(W) prefix levels, sum = P ^ carry.
  function automatic logic [W:0] ks_add(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         cin
  );
    logic [W-1:0] p0;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    p0   = x ^ y;
    g    = x & y;
    p    = p0;
    g[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < W; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < W; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return {g[W-1], p0 ^ {g[W-2:0], cin}};
  endfunction

  assign accept = in_valid && in_ready;
  assign last   = (idx == IW'(LIMBS - 1));
  assign la     = a_r[idx*W +: W];
  assign lb     = b_r[idx*W +: W];
  assign ks     = ks_add(la, lb, carry);
  assign sum    = sum_r;
  assign cout   = cout_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: accept -> RUN, last limb -> DONE, handshake -> IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Operand capture and limb-serial datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= op_sub ? ~b : b;
      carry <= op_sub;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_r[idx*W +: W] <= ks[W-1:0];
      carry             <= ks[W];
      idx               <= idx + 1'b1;
      if (last) cout_r  <= ks[W];
    end
  end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter: W, 32, limb width in bits.
REQ-002 Parameter: LIMBS, 4, number of limbs per operand (≥2).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set on a, b, op_sub is valid.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  W*LIMBS  operand A, unsigned, limb 0 = bits [W-1:0].
REQ-008 b  input  W*LIMBS  operand B, unsigned.
REQ-009 op_sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result on sum/cout is valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  W*LIMBS  result, modulo 2^(W*LIMBS).
REQ-013 cout  output  1  add: carry out; sub: 1 = no borrow (A≥B).
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 The block SHALL compute the wide result one W-bit limb per cycle through a single W-bit Kogge-Stone prefix adder with carry-in (G/P generate, log2(W) prefix levels, sum = P ^ carry).
REQ-016 FSM states SHALL be IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 Accept occurs on a cycle with in_valid && in_ready; the block SHALL latch a, b (b inverted when op_sub=1), and set carry register = op_sub, limb index = 0, state → RUN.
REQ-018 In RUN, each cycle the block SHALL add limb[idx] of latched A and B with the carry register, write the W-bit result into sum limb idx, store the carry-out, and increment idx.
REQ-019 When idx == LIMBS-1 is processed, the state SHALL go to DONE and cout SHALL take the final carry-out.
REQ-020 Latency: accept on edge t → out_valid high after edge t+LIMBS (first DONE cycle; 4 cycles after accept at default).
REQ-021 In DONE, sum and cout SHALL hold stable until out_ready is high; on out_valid && out_ready the state SHALL return to IDLE (in_ready high the following cycle).
REQ-022 No overlap: in_valid SHALL be ignored outside IDLE; a and b changes outside IDLE SHALL not affect the result.
REQ-023 Operands/op_sub SHALL be captured only on the accept edge; subtraction uses two's complement (A + ~B + 1).
REQ-024 Carry-out of limb LIMBS-1 SHALL not wrap into limb 0; the sum is modulo 2^(W*LIMBS).
REQ-025 Throughput: one result per LIMBS+2 cycles maximum (accept, LIMBS compute cycles folded with DONE, IDLE return).

Reset
REQ-026 While rst is high at a clock edge: state = IDLE, idx = 0, carry = 0, sum = 0, cout = 0, out_valid = 0, busy = 0; in_ready SHALL be 1 in the cycle after the reset edge.
REQ-027 rst asserted in RUN or DONE SHALL abort the operation with no out_valid pulse; the pending result is discarded.
REQ-028 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-029 Add, W=32, LIMBS=4: a=0x0000..0_FFFFFFFF, b=1, op_sub=0 → after 4 cycles sum=0x00000000_00000000_00000001_00000000, cout=0.
REQ-030 Full carry ripple: a=all ones (128 bits), b=1 → sum=0, cout=1; out_valid held 3 extra cycles with out_ready=0, sum stable throughout.
REQ-031 Subtract: a=5, b=7, op_sub=1 → sum=0xFFFF...FFFE (128 bits), cout=0; a=7, b=5 → sum=2, cout=1.
REQ-032 Back-pressure/no-overlap: in_valid held high continuously with changing operands → exactly one accept per transaction, in_ready low from accept through the handshake cycle; each result matches the operands present on its accept edge.
REQ-033 Reset mid-operation: assert rst 2 cycles after accept → no out_valid, in_ready=1 next cycle, following transaction (a=3, b=4) yields sum=7, cout=0.
REQ-034 Random: ≥10,000 random a, b, op_sub with random out_ready stalls, compared against a 129-bit reference model.
